// File: rtl/multiport_mem_if.sv
// Bus bundle for multiport_mem: one byte-enabled write port, NUM_RD read ports,
// and the clear-engine request/status pair.
interface multiport_mem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 11,
    parameter int NUM_RD = 2
);
    // Handshake: w_en, r_en[p] and clr_req are single-cycle requests with no
    // backpressure. They are accepted only while busy=0. r_valid[p] qualifies
    // data_out port p for exactly one cycle, and data_out holds between reads.
    logic                     w_en;
    logic [ADDR_W-1:0]        w_adrs;
    logic [DATA_W/8-1:0]      w_be;
    logic [DATA_W-1:0]        data_in;
    logic [NUM_RD-1:0]        r_en;
    logic [NUM_RD*ADDR_W-1:0] r_adrs;
    logic [NUM_RD*DATA_W-1:0] data_out;
    logic [NUM_RD-1:0]        r_valid;
    logic                     clr_req;
    logic                     busy;

    modport master (
        output w_en, w_adrs, w_be, data_in, r_en, r_adrs, clr_req,
        input  data_out, r_valid, busy
    );

    modport slave (
        input  w_en, w_adrs, w_be, data_in, r_en, r_adrs, clr_req,
        output data_out, r_valid, busy
    );
endinterface

// File: rtl/multiport_mem.sv
// Multi-read-port, byte-enabled RAM with a sequential clear engine that
// sweeps the whole array to zero after reset or on request.
module multiport_mem #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 11,
    parameter int NUM_RD   = 2,
    parameter int RD_LAT   = 1,
    parameter int WR_FIRST = 0
) (
    input  logic           clk,
    input  logic           reset,
    multiport_mem_if.slave bus,
    output logic           dbg_state
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              idle;
    logic              wr_go;
    logic [ADDR_W-1:0] r_addr  [NUM_RD];
    logic [DATA_W-1:0] rd_word [NUM_RD];
    logic [NUM_RD-1:0] v1;
    logic [DATA_W-1:0] d1      [NUM_RD];

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // A clear request seen while already clearing is ignored, not restarted.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            CLEAR: begin
                clr_cnt_nxt = clr_cnt + 1'b1;
                if (clr_cnt == {ADDR_W{1'b1}}) state_nxt = IDLE;
            end
            IDLE: begin
                if (bus.clr_req) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    assign idle      = (state == IDLE);
    assign bus.busy  = (state == CLEAR);
    assign dbg_state = state;
    assign wr_go     = idle && bus.w_en && !reset;

    always_ff @(posedge clk) begin
        if (!idle) begin
            mem[clr_cnt] <= '0;
        end else if (wr_go) begin
            for (int b = 0; b < NB; b++)
                if (bus.w_be[b]) mem[bus.w_adrs][8*b +: 8] <= bus.data_in[8*b +: 8];
        end
    end

    // Array read with optional write-first bypass of the enabled bytes.
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            r_addr[p]  = bus.r_adrs[p*ADDR_W +: ADDR_W];
            rd_word[p] = mem[r_addr[p]];
            if (WR_FIRST != 0 && wr_go && bus.w_adrs == r_addr[p]) begin
                for (int b = 0; b < NB; b++)
                    if (bus.w_be[b]) rd_word[p][8*b +: 8] = bus.data_in[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v1 <= '0;
            for (int p = 0; p < NUM_RD; p++) d1[p] <= '0;
        end else begin
            for (int p = 0; p < NUM_RD; p++) begin
                v1[p] <= idle && bus.r_en[p];
                if (idle && bus.r_en[p]) d1[p] <= rd_word[p];
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [NUM_RD-1:0] v2;
            logic [DATA_W-1:0] d2 [NUM_RD];

            always_ff @(posedge clk) begin
                if (reset) begin
                    v2 <= '0;
                    for (int p = 0; p < NUM_RD; p++) d2[p] <= '0;
                end else begin
                    v2 <= v1;
                    for (int p = 0; p < NUM_RD; p++)
                        if (v1[p]) d2[p] <= d1[p];
                end
            end

            assign bus.r_valid = v2;
            for (genvar p = 0; p < NUM_RD; p++) begin : g_out
                assign bus.data_out[p*DATA_W +: DATA_W] = d2[p];
            end
        end else begin : g_lat1
            assign bus.r_valid = v1;
            for (genvar p = 0; p < NUM_RD; p++) begin : g_out
                assign bus.data_out[p*DATA_W +: DATA_W] = d1[p];
            end
        end
    endgenerate
endmodule

// File: tb/tb_multiport_mem.sv
// Bench for multiport_mem: three instances (old-data, new-data, two-cycle latency)
// driven with identical stimulus and compared against a word-array reference model.
module tb_multiport_mem;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NR = 2;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multiport_mem_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) if_a ();
    multiport_mem_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) if_b ();
    multiport_mem_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) if_c ();
    logic dbg_a, dbg_b, dbg_c;

    multiport_mem #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .RD_LAT(1), .WR_FIRST(0))
        dut_a (.clk(clk), .reset(reset), .bus(if_a.slave), .dbg_state(dbg_a));
    multiport_mem #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .RD_LAT(1), .WR_FIRST(1))
        dut_b (.clk(clk), .reset(reset), .bus(if_b.slave), .dbg_state(dbg_b));
    multiport_mem #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .RD_LAT(2), .WR_FIRST(0))
        dut_c (.clk(clk), .reset(reset), .bus(if_c.slave), .dbg_state(dbg_c));

    // if_a carries the stimulus; the other two instances see the same requests
    assign if_b.w_en = if_a.w_en;       assign if_c.w_en = if_a.w_en;
    assign if_b.w_adrs = if_a.w_adrs;   assign if_c.w_adrs = if_a.w_adrs;
    assign if_b.w_be = if_a.w_be;       assign if_c.w_be = if_a.w_be;
    assign if_b.data_in = if_a.data_in; assign if_c.data_in = if_a.data_in;
    assign if_b.r_en = if_a.r_en;       assign if_c.r_en = if_a.r_en;
    assign if_b.r_adrs = if_a.r_adrs;   assign if_c.r_adrs = if_a.r_adrs;
    assign if_b.clr_req = if_a.clr_req; assign if_c.clr_req = if_a.clr_req;

    // reference model
    logic [DW-1:0] mem_m [DEPTH];
    int            rem;
    logic [NR-1:0] e1_v, e2_v;
    logic [DW-1:0] e1_old [NR], e1_new [NR], e2_d [NR];
    logic [DW-1:0] exp_q [$];

    int checks = 0;
    int errors = 0;

    function automatic logic [DW-1:0] get_d(input logic [NR*DW-1:0] v, input int p);
        return v[p*DW +: DW];
    endfunction

    task automatic idle_inputs();
        if_a.w_en = 1'b0; if_a.w_adrs = '0; if_a.w_be = '0; if_a.data_in = '0;
        if_a.r_en = '0; if_a.r_adrs = '0; if_a.clr_req = 1'b0;
    endtask

    // Advance the model by one clock using the current inputs, then clock the DUTs.
    task automatic step();
        logic [DW-1:0] old_w, new_w;
        logic [AW-1:0] ra;
        if (reset) begin
            e1_v = '0; e2_v = '0;
            for (int p = 0; p < NR; p++) begin e1_old[p] = '0; e1_new[p] = '0; e2_d[p] = '0; end
            for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
            rem = DEPTH;
        end else begin
            e2_v = e1_v;
            for (int p = 0; p < NR; p++) e2_d[p] = e1_old[p];
            if (rem > 0) begin
                e1_v = '0;
                rem--;
            end else begin
                for (int p = 0; p < NR; p++) begin
                    ra = if_a.r_adrs[p*AW +: AW];
                    e1_v[p] = if_a.r_en[p];
                    if (if_a.r_en[p]) begin
                        old_w = mem_m[ra];
                        new_w = old_w;
                        if (if_a.w_en && if_a.w_adrs == ra)
                            for (int b = 0; b < DW/8; b++)
                                if (if_a.w_be[b]) new_w[8*b +: 8] = if_a.data_in[8*b +: 8];
                        e1_old[p] = old_w;
                        e1_new[p] = new_w;
                    end
                end
                if (if_a.w_en)
                    for (int b = 0; b < DW/8; b++)
                        if (if_a.w_be[b]) mem_m[if_a.w_adrs][8*b +: 8] = if_a.data_in[8*b +: 8];
                if (if_a.clr_req) begin
                    rem = DEPTH;
                    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int cnt;
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({if_a.busy, if_b.busy, if_c.busy} !== 3'b111) begin
            errors++; $display("FAIL reset_busy got %b exp 111", {if_a.busy, if_b.busy, if_c.busy});
        end
        checks++;
        if ({if_a.r_valid, if_b.r_valid, if_c.r_valid} !== 6'b0) begin
            errors++; $display("FAIL reset_valid got %b exp 0", {if_a.r_valid, if_b.r_valid, if_c.r_valid});
        end
        checks++;
        if ({if_a.data_out, if_b.data_out, if_c.data_out} !== '0) begin
            errors++; $display("FAIL reset_data got %h exp 0", {if_a.data_out, if_b.data_out, if_c.data_out});
        end
        cnt = 0;
        while (if_a.busy === 1'b1 && cnt < 40) begin
            cnt++;
            step();
            checks++;
            if (if_c.busy !== (rem > 0)) begin
                errors++; $display("FAIL reset_busy_c got %b exp %b", if_c.busy, (rem > 0));
            end
        end
        checks++;
        if (cnt !== 16) begin errors++; $display("FAIL reset_busy_len got %0d exp 16", cnt); end
    endtask

    task automatic test_clear_read();
        logic [DW-1:0] e;
        for (int a = 0; a < DEPTH; a++) begin
            if_a.r_en = 2'b11;
            if_a.r_adrs = {4'(15 - a), 4'(a)};
            exp_q.push_back(mem_m[a]);
            step();
            checks++;
            if (if_a.r_valid !== 2'b11) begin
                errors++; $display("FAIL clear_read_valid addr %0d got %b exp 11", a, if_a.r_valid);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (get_d(if_a.data_out, 0) !== e || e !== 32'h0 || get_d(if_a.data_out, 1) !== 32'h0) begin
                    errors++; $display("FAIL clear_read_data addr %0d got %h exp %h", a, if_a.data_out, 64'h0);
                end
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_byte_enable();
        idle_inputs();
        if_a.w_en = 1'b1; if_a.w_adrs = 4'd3; if_a.w_be = 4'b1111; if_a.data_in = 32'hDEADBEEF;
        step();
        if_a.w_be = 4'b0101; if_a.data_in = 32'h11223344;
        step();
        if_a.w_be = 4'b0000; if_a.data_in = 32'hFFFFFFFF;
        step();
        idle_inputs();
        if_a.r_en = 2'b01; if_a.r_adrs = {4'd0, 4'd3};
        step();
        checks++;
        if (if_a.r_valid[0] !== 1'b1 || get_d(if_a.data_out, 0) !== 32'hDE22BE44) begin
            errors++; $display("FAIL byte_enable got v=%b %h exp v=1 DE22BE44", if_a.r_valid[0], get_d(if_a.data_out, 0));
        end
        checks++;
        if (if_b.r_valid[1] !== 1'b0) begin errors++; $display("FAIL byte_enable_p1_valid got %b exp 0", if_b.r_valid[1]); end
        if_a.r_en = 2'b00;
        step();
        checks++;
        if (if_a.r_valid[0] !== 1'b0 || get_d(if_a.data_out, 0) !== 32'hDE22BE44) begin
            errors++; $display("FAIL hold_data got v=%b %h exp v=0 DE22BE44", if_a.r_valid[0], get_d(if_a.data_out, 0));
        end
    endtask

    task automatic test_collision();
        idle_inputs();
        if_a.w_en = 1'b1; if_a.w_adrs = 4'd5; if_a.w_be = 4'b1111; if_a.data_in = 32'hAAAAAAAA;
        step();
        if_a.w_be = 4'b0011; if_a.data_in = 32'h55555555;
        if_a.r_en = 2'b01; if_a.r_adrs = {4'd0, 4'd5};
        step();
        checks++;
        if (get_d(if_a.data_out, 0) !== 32'hAAAAAAAA) begin
            errors++; $display("FAIL collision_old got %h exp AAAAAAAA", get_d(if_a.data_out, 0));
        end
        checks++;
        if (get_d(if_b.data_out, 0) !== 32'hAAAA5555) begin
            errors++; $display("FAIL collision_new got %h exp AAAA5555", get_d(if_b.data_out, 0));
        end
        idle_inputs();
        if_a.r_en = 2'b11; if_a.r_adrs = {4'd5, 4'd5};
        step();
        checks++;
        if (if_a.data_out !== {32'hAAAA5555, 32'hAAAA5555} || if_a.r_valid !== 2'b11) begin
            errors++; $display("FAIL same_addr got %h v=%b exp AAAA5555AAAA5555 v=11", if_a.data_out, if_a.r_valid);
        end
    endtask

    task automatic test_rd_lat2();
        idle_inputs();
        if_a.w_en = 1'b1; if_a.w_adrs = 4'd7; if_a.w_be = 4'b1111; if_a.data_in = 32'h12345678;
        step();
        idle_inputs();
        if_a.r_en = 2'b11; if_a.r_adrs = {4'd7, 4'd7};
        step();
        if_a.r_en = 2'b00;
        checks++;
        if (if_c.r_valid !== 2'b00) begin errors++; $display("FAIL lat2_early got %b exp 00", if_c.r_valid); end
        step();
        checks++;
        if (if_c.r_valid !== 2'b11 || if_c.data_out !== {32'h12345678, 32'h12345678}) begin
            errors++; $display("FAIL lat2_data got v=%b %h exp v=11 1234567812345678", if_c.r_valid, if_c.data_out);
        end
        step();
        checks++;
        if (if_c.r_valid !== 2'b00) begin errors++; $display("FAIL lat2_late got %b exp 00", if_c.r_valid); end
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            if_a.w_en = 1'($urandom_range(0, 1));
            if_a.w_adrs = 4'($urandom_range(0, 15));
            if_a.w_be = 4'($urandom_range(0, 15));
            if_a.data_in = $urandom();
            if_a.r_en = 2'($urandom_range(0, 3));
            if_a.r_adrs = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
            if ($urandom_range(0, 2) == 0) if_a.r_adrs[AW-1:0] = if_a.w_adrs;
            if_a.clr_req = ($urandom_range(0, 99) == 0);
            step();
            checks++;
            if (if_a.busy !== (rem > 0)) begin errors++; $display("FAIL rand_busy cyc %0d got %b exp %b", i, if_a.busy, (rem > 0)); end
            for (int p = 0; p < NR; p++) begin
                checks++;
                if ({if_a.r_valid[p], get_d(if_a.data_out, p)} !== {e1_v[p], e1_old[p]}) begin
                    errors++; $display("FAIL rand_a cyc %0d p%0d got %b %h exp %b %h", i, p, if_a.r_valid[p], get_d(if_a.data_out, p), e1_v[p], e1_old[p]);
                end
                checks++;
                if ({if_b.r_valid[p], get_d(if_b.data_out, p)} !== {e1_v[p], e1_new[p]}) begin
                    errors++; $display("FAIL rand_b cyc %0d p%0d got %b %h exp %b %h", i, p, if_b.r_valid[p], get_d(if_b.data_out, p), e1_v[p], e1_new[p]);
                end
                checks++;
                if ({if_c.r_valid[p], get_d(if_c.data_out, p)} !== {e2_v[p], e2_d[p]}) begin
                    errors++; $display("FAIL rand_c cyc %0d p%0d got %b %h exp %b %h", i, p, if_c.r_valid[p], get_d(if_c.data_out, p), e2_v[p], e2_d[p]);
                end
            end
        end
        idle_inputs();
        for (int i = 0; i < 40 && if_a.busy === 1'b1; i++) step();
    endtask

    task automatic test_clr_req();
        int cnt;
        idle_inputs();
        for (int a = 0; a < DEPTH; a++) begin
            if_a.w_en = 1'b1; if_a.w_adrs = 4'(a); if_a.w_be = 4'b1111; if_a.data_in = $urandom() | 32'h1;
            step();
        end
        idle_inputs();
        if_a.clr_req = 1'b1;
        step();
        cnt = 0;
        while (if_a.busy === 1'b1 && cnt < 40) begin
            cnt++;
            if_a.clr_req = 1'($urandom_range(0, 1));
            if_a.w_en = 1'b1; if_a.w_adrs = 4'($urandom_range(0, 15)); if_a.w_be = 4'b1111;
            if_a.data_in = $urandom() | 32'h1;
            if_a.r_en = 2'b11; if_a.r_adrs = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
            step();
            checks++;
            if ({if_a.r_valid, if_b.r_valid, if_c.r_valid} !== 6'b0) begin
                errors++; $display("FAIL clr_valid cyc %0d got %b exp 0", cnt, {if_a.r_valid, if_b.r_valid, if_c.r_valid});
            end
        end
        checks++;
        if (cnt !== 16) begin errors++; $display("FAIL clr_busy_len got %0d exp 16", cnt); end
        idle_inputs();
        for (int a = 0; a < DEPTH; a++) begin
            if_a.r_en = 2'b11; if_a.r_adrs = {4'(a), 4'(a)};
            step();
            checks++;
            if (if_a.r_valid !== 2'b11 || if_a.data_out !== 64'h0 || if_b.data_out !== 64'h0) begin
                errors++; $display("FAIL clr_zero addr %0d got v=%b %h %h exp v=11 0", a, if_a.r_valid, if_a.data_out, if_b.data_out);
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid_clear();
        int cnt;
        idle_inputs();
        if_a.clr_req = 1'b1;
        step();
        if_a.clr_req = 1'b0;
        for (int i = 0; i < 7; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        cnt = 0;
        while (if_a.busy === 1'b1 && cnt < 40) begin
            cnt++;
            if_a.r_en = 2'b11; if_a.r_adrs = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
            step();
            checks++;
            if ({if_a.r_valid, if_c.r_valid} !== 4'b0) begin
                errors++; $display("FAIL midclr_valid cyc %0d got %b exp 0", cnt, {if_a.r_valid, if_c.r_valid});
            end
        end
        checks++;
        if (cnt !== 16) begin errors++; $display("FAIL midclr_busy_len got %0d exp 16", cnt); end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_inflight();
        idle_inputs();
        if_a.r_en = 2'b11; if_a.r_adrs = {4'd2, 4'd9};
        step();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (if_c.r_valid !== 2'b00 || if_c.data_out !== 64'h0) begin
            errors++; $display("FAIL inflight_drop got v=%b %h exp v=00 0", if_c.r_valid, if_c.data_out);
        end
        for (int i = 0; i < 40 && if_a.busy === 1'b1; i++) step();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_clear_read();
        test_byte_enable();
        test_collision();
        test_rd_lat2();
        test_random(400);
        test_clr_req();
        test_reset_mid_clear();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multiport_mem.md
MULTIPORT_MEM -- requirements
Module: multiport_mem

Interface
Parameters:
REQ-001 The block SHALL have parameter DATA_W, default 32: word width; SHALL be a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_W, default 11: address width; depth = 2**ADDR_W.
REQ-003 The block SHALL have parameter NUM_RD, default 2: number of independent read ports (1..4).
REQ-004 The block SHALL have parameter RD_LAT, default 1: read latency in cycles (1 or 2).
REQ-005 The block SHALL have parameter WR_FIRST, default 0: read/write collision mode (0 = old data, 1 = new data).

Ports:
REQ-006 The block SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-008 The block SHALL have port w_en, input, 1 bit: write request.
REQ-009 The block SHALL have port w_adrs, input, ADDR_W bits: write address.
REQ-010 The block SHALL have port w_be, input, DATA_W/8 bits: byte enables; bit k covers data bits [8k+7:8k].
REQ-011 The block SHALL have port data_in, input, DATA_W bits: write data.
REQ-012 The block SHALL have port r_en, input, NUM_RD bits: per-port read request.
REQ-013 The block SHALL have port r_adrs, input, NUM_RD*ADDR_W bits: port p address at [p*ADDR_W +: ADDR_W].
REQ-014 The block SHALL have port data_out, output, NUM_RD*DATA_W bits: port p data at [p*DATA_W +: DATA_W].
REQ-015 The block SHALL have port r_valid, output, NUM_RD bits: per-port data_out qualifier.
REQ-016 The block SHALL have port clr_req, input, 1 bit: request a full-array clear.
REQ-017 The block SHALL have port busy, output, 1 bit: high while the clear engine runs.

Function
REQ-018 The block SHALL have exactly two states: CLEAR and IDLE.
REQ-019 In CLEAR, the block SHALL write zero to address clr_cnt each cycle, increment clr_cnt, and go to IDLE after writing address 2**ADDR_W-1; a clear SHALL take exactly 2**ADDR_W cycles.
REQ-020 In IDLE, clr_req=1 SHALL move the block to CLEAR with clr_cnt=0 on the next edge; clr_req while in CLEAR SHALL be ignored (no restart).
REQ-021 busy SHALL equal (state==CLEAR) as a registered output.
REQ-022 While busy=1, w_en and r_en SHALL be ignored: no array write from the user port, and r_valid SHALL not assert for those requests.
REQ-023 In IDLE with w_en=1, only the bytes with w_be[k]=1 SHALL be updated at w_adrs; w_be=0 SHALL leave the word unchanged.
REQ-024 In IDLE, r_en[p]=1 SHALL produce the data for r_adrs port p on data_out port p with r_valid[p]=1 exactly RD_LAT cycles later.
REQ-025 When RD_LAT=2, the block SHALL add one output register stage, and r_valid SHALL be delayed to match.
REQ-026 When r_en[p]=0, data_out port p SHALL hold its last value, and r_valid[p] SHALL be 0 in the corresponding cycle.
REQ-027 On a same-cycle read and write to the same address with WR_FIRST=0, the read SHALL return the pre-write word.
REQ-028 On a same-cycle read and write to the same address with WR_FIRST=1, the read SHALL return the byte-merged word (new bytes where w_be=1, old bytes elsewhere).
REQ-029 Multiple read ports SHALL be allowed to read the same address in the same cycle, and each SHALL return an identical word.
REQ-030 Address arithmetic SHALL wrap naturally at ADDR_W bits; there SHALL be no out-of-range case.

Reset
REQ-031 When reset=1 at a clock edge, the block SHALL enter CLEAR with clr_cnt=0 and SHALL set busy=1, r_valid=0, data_out=0, and all pipeline stages to 0.
REQ-032 reset asserted mid-clear SHALL restart the sweep from address 0.
REQ-033 reset asserted during a read pipeline SHALL drop in-flight reads, leaving r_valid=0.
REQ-034 The array SHALL be all-zero only after busy falls; readers SHALL not depend on array contents before that.

Verification (ADDR_W=4, DATA_W=32, NUM_RD=2 unless noted)
REQ-035 Reset released: busy=1 for exactly 16 cycles then 0; reading all 16 addresses then returns 0x00000000 with r_valid=1 one cycle after each r_en.
REQ-036 Write 0xDEADBEEF to addr 3 with w_be=4'b1111, then write 0x11223344 with w_be=4'b0101: a read of addr 3 returns 0xDE22BE44.
REQ-037 Collision case: addr 5 holds 0xAAAAAAAA; in the same cycle, write 0x55555555 with w_be=4'b0011 and read addr 5 on port 0; WR_FIRST=0 returns 0xAAAAAAAA and WR_FIRST=1 returns 0xAAAA5555.
REQ-038 RD_LAT=2: read of addr 7 (holding 0x12345678) on both ports in one cycle gives both data_out=0x12345678 and r_valid=2'b11 exactly two cycles later; r_valid stays 0 one cycle later.
REQ-039 clr_req pulsed in IDLE after filling memory: busy high 16 cycles, writes and reads issued meanwhile are ignored (r_valid=0), and all reads return 0 afterwards.
REQ-040 reset pulsed at cycle 8 of a clear: busy stays 1 for a further 16 cycles after reset deasserts, with r_valid=0 throughout.
